// File: rtl/dcache_fill_fsm.sv
// D-cache miss-fill controller: fetches a whole block from main memory, streams words into the
// data array, writes the tag last. Define DCACHE_FILL_CRIT_FIRST_EN for critical-word-first order.
`timescale 1ns/1ps

module dcache_fill_fsm #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned ADDR_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic                               mem_data_valid,
    input  logic [ADDR_W-1:0]                  mem_data_in,
    output logic                               fsm_busy,
    output logic                               mem_rd_en,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic                               data_array_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_array_word,
    output logic [ADDR_W-1:0]                  fill_data,
    output logic                               tag_array_we,
    output logic                               crit_word_rdy,
    output logic                               fill_done
);

    localparam int unsigned     IdxW     = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned     BlkW     = ADDR_W - IdxW - 1;
    localparam logic [IdxW:0]   NumWords = (IdxW + 1)'(WORDS_PER_BLOCK);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e          state_q, state_d;
    logic [IdxW:0]   issue_cnt_q, issue_cnt_d;
    logic [IdxW-1:0] recv_cnt_q, recv_cnt_d;
    logic [BlkW-1:0] blk_q, blk_d;
    logic [IdxW-1:0] req_q, req_d;

    logic            in_fill;
    logic            last_word;
    logic [IdxW-1:0] issue_word;
    logic [IdxW-1:0] recv_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            blk_q       <= '0;
            req_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            blk_q       <= blk_d;
            req_q       <= req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        blk_d       = blk_q;
        req_d       = req_q;
        case (state_q)
            StIdle: begin
                if (miss_detected) begin
                    state_d     = StFill;
                    blk_d       = miss_address[ADDR_W-1 -: BlkW];
                    req_d       = miss_address[IdxW:1];
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            StFill: begin
                if (mem_rd_en) issue_cnt_d = issue_cnt_q + (IdxW + 1)'(1);
                if (data_array_we) recv_cnt_d = recv_cnt_q + IdxW'(1);
                // Misses arriving while filling are dropped; a held miss re-triggers from idle.
                if (last_word) begin
                    state_d     = StIdle;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_fill = (state_q == StFill);
`ifdef DCACHE_FILL_CRIT_FIRST_EN
        issue_word = req_q + issue_cnt_q[IdxW-1:0];
        recv_word  = req_q + recv_cnt_q;
`else
        issue_word = issue_cnt_q[IdxW-1:0];
        recv_word  = recv_cnt_q;
`endif
        fsm_busy        = in_fill;
        mem_rd_en       = in_fill && (issue_cnt_q < NumWords);
        mem_addr        = mem_rd_en ? {blk_q, issue_word, 1'b0} : '0;
        // Memory returns in order, so the receive count alone identifies the word.
        data_array_we   = in_fill && mem_data_valid;
        data_array_word = in_fill ? recv_word : '0;
        fill_data       = mem_data_in;
        last_word       = data_array_we && (recv_cnt_q == LastIdx);
        tag_array_we    = last_word;
        fill_done       = last_word;
        crit_word_rdy   = data_array_we && (recv_word == req_q);
    end

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Directed bench for dcache_fill_fsm with an in-order, fixed-latency main-memory model.
`timescale 1ns/1ps

module tb_dcache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data_in = '0;
    logic        fsm_busy, mem_rd_en, data_array_we, tag_array_we, crit_word_rdy, fill_done;
    logic [15:0] mem_addr, fill_data;
    logic [2:0]  data_array_word;

    int checks = 0;
    int errors = 0;

    dcache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_detected  (miss_detected),
        .miss_address   (miss_address),
        .mem_data_valid (mem_data_valid),
        .mem_data_in    (mem_data_in),
        .fsm_busy       (fsm_busy),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .data_array_we  (data_array_we),
        .data_array_word(data_array_word),
        .fill_data      (fill_data),
        .tag_array_we   (tag_array_we),
        .crit_word_rdy  (crit_word_rdy),
        .fill_done      (fill_done)
    );

    always #5 clk = ~clk;

`ifdef DCACHE_FILL_CRIT_FIRST_EN
    localparam int CritPos = 1;
`else
    localparam int CritPos = 4;
`endif

    // Memory model: returns addr ^ 5A5A, lat cycles after the read, strictly in order.
    typedef struct {
        logic [15:0] a;
        int          due;
    } rd_t;
    rd_t rq[$];
    rd_t r_tmp;
    int  lat = 4;
    int  cyc = 0;
    int  stray_n = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_data_valid = 1'b1;
            mem_data_in    = rq[0].a ^ 16'h5A5A;
            rq.delete(0);
        end else if (stray_n > 0) begin
            mem_data_valid = 1'b1;
            mem_data_in    = 16'hDEAD;
            stray_n--;
        end else begin
            mem_data_valid = 1'b0;
            mem_data_in    = '0;
        end
    end

    always @(negedge clk) begin
        if (mem_rd_en) begin
            r_tmp.a   = mem_addr;
            r_tmp.due = cyc + lat;
            rq.push_back(r_tmp);
        end
    end

    logic [15:0] iss[$];
    logic [2:0]  wr_word[$];
    logic [15:0] wr_data[$];
    int crit_n, crit_pos, tag_n, done_n, iss_first_i, iss_last_i;
    bit timed_out;

    function automatic logic [2:0] exp_word(input int k, input logic [2:0] req);
`ifdef DCACHE_FILL_CRIT_FIRST_EN
        return req + k[2:0];
`else
        return k[2:0];
`endif
    endfunction

    // Records one fill, from the current cycle up to and including the fill_done cycle.
    task automatic collect(input int bound);
        iss.delete();
        wr_word.delete();
        wr_data.delete();
        crit_n = 0; crit_pos = 0; tag_n = 0; done_n = 0;
        iss_first_i = -1; iss_last_i = -1;
        timed_out = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (mem_rd_en) begin
                iss.push_back(mem_addr);
                if (iss_first_i < 0) iss_first_i = i;
                iss_last_i = i;
            end
            if (data_array_we) begin
                wr_word.push_back(data_array_word);
                wr_data.push_back(fill_data);
            end
            if (crit_word_rdy) begin
                crit_n++;
                crit_pos = wr_word.size();
            end
            if (tag_array_we) tag_n++;
            if (fill_done) begin
                done_n++;
                return;
            end
        end
        timed_out = 1'b1;
    endtask

    task automatic start_miss(input logic [15:0] a);
        @(posedge clk); #2;
        miss_detected = 1'b1;
        miss_address  = a;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({fsm_busy, mem_rd_en, data_array_we, data_array_word, tag_array_we, crit_word_rdy,
             fill_done, fill_data} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b rd=%b we=%b word=%0d tag=%b crit=%b done=%b, want all 0",
                     fsm_busy, mem_rd_en, data_array_we, data_array_word, tag_array_we,
                     crit_word_rdy, fill_done);
        end
        checks++;
        if (mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h want 0000", mem_addr);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (fsm_busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b rd=%b want 0 0", fsm_busy, mem_rd_en);
        end
    endtask

    task automatic test_fill_order();
        logic [15:0] exp_a [8];
        logic [2:0]  exp_w [8];
`ifdef DCACHE_FILL_CRIT_FIRST_EN
        exp_a = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
        exp_w = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
`else
        exp_a = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
        exp_w = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        lat = 4;
        start_miss(16'h1236);
        checks++;
        if (fsm_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_miss_cycle: got %b want 0", fsm_busy);
        end
        @(posedge clk); #2;
        miss_detected = 1'b0;
        collect(80);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL order_timeout: got no fill_done want fill_done within 80 cycles");
        end
        checks++;
        if (iss.size() != 8 || iss_first_i != 0 || iss_last_i != 7) begin
            errors++;
            $display("FAIL order_issue: got %0d reads at cycles %0d..%0d want 8 at 0..7",
                     iss.size(), iss_first_i, iss_last_i);
        end
        for (int k = 0; k < 8 && k < iss.size(); k++) begin
            checks++;
            if (iss[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL order_addr[%0d]: got %h want %h", k, iss[k], exp_a[k]);
            end
        end
        checks++;
        if (wr_word.size() != 8) begin
            errors++;
            $display("FAIL order_wcount: got %0d want 8", wr_word.size());
        end
        for (int k = 0; k < 8 && k < wr_word.size(); k++) begin
            checks++;
            if (wr_word[k] !== exp_w[k] || wr_data[k] !== (exp_a[k] ^ 16'h5A5A)) begin
                errors++;
                $display("FAIL order_write[%0d]: got word %0d data %h want word %0d data %h",
                         k, wr_word[k], wr_data[k], exp_w[k], exp_a[k] ^ 16'h5A5A);
            end
        end
        checks++;
        if (crit_n != 1 || crit_pos != CritPos) begin
            errors++;
            $display("FAIL order_crit: got %0d pulses at write %0d want 1 at write %0d",
                     crit_n, crit_pos, CritPos);
        end
        checks++;
        if (tag_n != 1 || done_n != 1) begin
            errors++;
            $display("FAIL order_tag_done: got tag=%0d done=%0d want 1 1", tag_n, done_n);
        end
        @(negedge clk);
        checks++;
        if (fsm_busy !== 1'b0) begin
            errors++;
            $display("FAIL order_idle_after: got busy=%b want 0", fsm_busy);
        end
    endtask

    task automatic test_back_to_back();
        lat = 4;
        start_miss(16'h0040);
        collect(80);
        checks++;
        if (timed_out || done_n != 1 || iss.size() != 8) begin
            errors++;
            $display("FAIL b2b_first: got done=%0d reads=%0d timeout=%0b want 1 8 0",
                     done_n, iss.size(), timed_out);
        end
        checks++;
        if (iss.size() == 8 && (iss[0] !== 16'h0040 || iss[7] !== 16'h004E)) begin
            errors++;
            $display("FAIL b2b_first_addr: got %h..%h want 0040..004E", iss[0], iss[7]);
        end
        @(posedge clk); #2;
        miss_address = 16'h0080;
        @(negedge clk);
        checks++;
        if (fsm_busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got busy=%b rd=%b want 0 0", fsm_busy, mem_rd_en);
        end
        @(posedge clk); #2;
        miss_detected = 1'b0;
        collect(80);
        checks++;
        if (timed_out || done_n != 1 || iss.size() != 8 || iss_first_i != 0) begin
            errors++;
            $display("FAIL b2b_second: got done=%0d reads=%0d first=%0d want 1 8 0",
                     done_n, iss.size(), iss_first_i);
        end
        checks++;
        if (iss.size() > 0 && iss[0] !== 16'h0080) begin
            errors++;
            $display("FAIL b2b_second_addr: got %h want 0080", iss[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int we_seen = 0;
        int bad = 0;
        lat = 4;
        start_miss(16'h1236);
        @(posedge clk); #2;
        miss_detected = 1'b0;
        for (int i = 0; i < 40 && we_seen < 3; i++) begin
            @(negedge clk);
            if (data_array_we) we_seen++;
        end
        #1;
        rst = 1'b1;
        rq.delete();
        #1;
        checks++;
        if ({fsm_busy, mem_rd_en, data_array_we, tag_array_we, fill_done} !== 5'b0 ||
            mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b rd=%b we=%b tag=%b done=%b addr=%h want 0",
                     fsm_busy, mem_rd_en, data_array_we, tag_array_we, fill_done, mem_addr);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        stray_n = 5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_array_we || tag_array_we || fill_done || crit_word_rdy || fsm_busy ||
                mem_rd_en) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_stray: got %0d active cycles want 0", bad);
        end
        start_miss(16'h1236);
        @(posedge clk); #2;
        miss_detected = 1'b0;
        collect(80);
        checks++;
        if (timed_out || done_n != 1 || iss.size() != 8 || wr_word.size() != 8) begin
            errors++;
            $display("FAIL abort_refill: got done=%0d reads=%0d writes=%0d want 1 8 8",
                     done_n, iss.size(), wr_word.size());
        end
        for (int k = 0; k < 8 && k < wr_word.size(); k++) begin
            checks++;
            if (wr_word[k] !== exp_word(k, 3'd3)) begin
                errors++;
                $display("FAIL abort_refill_word[%0d]: got %0d want %0d",
                         k, wr_word[k], exp_word(k, 3'd3));
            end
        end
    endtask

    task automatic test_latency();
        logic [15:0] addrs [2];
        int          lats  [2];
        addrs = '{16'h5A5C, 16'hFFF2};
        lats  = '{1, 10};
        for (int t = 0; t < 2; t++) begin
            logic [2:0]  req;
            logic [15:0] a0;
            int          extra = 0;
            req = addrs[t][3:1];
            a0  = {addrs[t][15:4], exp_word(0, req), 1'b0};
            lat = lats[t];
            start_miss(addrs[t]);
            @(posedge clk); #2;
            miss_detected = 1'b0;
            collect(200);
            checks++;
            if (timed_out || iss.size() != 8 || done_n != 1 || tag_n != 1 || crit_n != 1) begin
                errors++;
                $display("FAIL lat%0d_counts: got reads=%0d done=%0d tag=%0d crit=%0d want 8 1 1 1",
                         lats[t], iss.size(), done_n, tag_n, crit_n);
            end
            checks++;
            if (iss.size() > 0 && iss[0] !== a0) begin
                errors++;
                $display("FAIL lat%0d_addr0: got %h want %h", lats[t], iss[0], a0);
            end
            for (int k = 0; k < 8 && k < wr_word.size(); k++) begin
                checks++;
                if (wr_word[k] !== exp_word(k, req)) begin
                    errors++;
                    $display("FAIL lat%0d_word[%0d]: got %0d want %0d",
                             lats[t], k, wr_word[k], exp_word(k, req));
                end
            end
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (mem_rd_en || data_array_we || fill_done) extra++;
            end
            checks++;
            if (extra != 0) begin
                errors++;
                $display("FAIL lat%0d_after: got %0d active cycles want 0", lats[t], extra);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_order();
        test_back_to_back();
        test_abort();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
